// File: rtl/seg_display_scanner_pkg.sv
// Shared 7-segment display definitions: active-low segment codes {g,f,e,d,c,b,a},
// the captured display value type and the digit-position select helper.
package seg_display_scanner_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned NUM_DIGITS = 7;

  typedef struct packed {
    logic                            positive;
    logic [NUM_DIGITS-1:0][3:0]      digits;
  } disp_val_t;

  localparam disp_val_t DISP_RESET = '{positive: 1'b1, digits: '0};

  function automatic logic [7:0] anode_sel(input logic [2:0] pos);
    return ~(8'b1 << pos);
  endfunction

endpackage

// File: rtl/seg_display_scanner_bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decode; non-decimal codes show E.
module bcd_to_seg
  import seg_display_scanner_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_E;
    case (digit_i)
      4'd0: seg_n_o = SEG_0;
      4'd1: seg_n_o = SEG_1;
      4'd2: seg_n_o = SEG_2;
      4'd3: seg_n_o = SEG_3;
      4'd4: seg_n_o = SEG_4;
      4'd5: seg_n_o = SEG_5;
      4'd6: seg_n_o = SEG_6;
      4'd7: seg_n_o = SEG_7;
      4'd8: seg_n_o = SEG_8;
      4'd9: seg_n_o = SEG_9;
      default: seg_n_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Eight-position multiplexed 7-segment scanner: shadow/display handshake updated only
// at frame boundaries, leading-zero blanking and sign at position 7, registered drive.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       positive,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       pending,
  output logic       frame_tick
);

  localparam int unsigned     PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    pos_q, pos_d;
  disp_val_t     shadow_q, shadow_d;
  disp_val_t     disp_q, disp_d;
  logic          pending_q, pending_d;
  logic [7:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;

  logic          term;
  logic          frame;
  logic [2:0]    top_nz;
  logic [7:0][3:0] dig_ext;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;

  assign term  = (presc_q == PRESC_LAST);
  assign frame = term && (pos_q == 3'd7);

  always_comb begin
    presc_d = term ? '0 : presc_q + PW'(1);
    pos_d   = term ? pos_q + 3'd1 : pos_q;
  end

  // Boundary copy uses the old shadow, so a load in the same cycle lands in the
  // shadow and stays pending for the next frame.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (frame && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = '{positive: positive, digits: {d6, d5, d4, d3, d2, d1, d0}};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    top_nz = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (disp_q.digits[k] != 4'd0) top_nz = 3'(k);
    end
  end

  assign dig_ext   = {4'h0, disp_q.digits};
  assign cur_digit = dig_ext[pos_q];

  bcd_to_seg u_dec (
    .digit_i (cur_digit),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    an_n_d = anode_sel(pos_q);
    if (pos_q == 3'd7)
      seg_n_d = disp_q.positive ? SEG_BLANK : SEG_MINUS;
    else if (pos_q > top_nz)
      seg_n_d = SEG_BLANK;
    else
      seg_n_d = dec_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pos_q     <= '0;
      shadow_q  <= DISP_RESET;
      disp_q    <= DISP_RESET;
      pending_q <= 1'b0;
      an_n_q    <= '1;
      seg_n_q   <= SEG_BLANK;
    end else begin
      presc_q   <= presc_d;
      pos_q     <= pos_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign pending    = pending_q;
  assign frame_tick = frame;

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks each digit position is lit; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port load, input, 1: one-cycle strobe capturing sign and digits.
REQ-005 SHALL have port positive, input, 1: sign flag from BCD converter; 1 = non-negative, 0 = negative.
REQ-006 SHALL have ports d0..d6, input, 4 each: BCD digits, d0 least significant.
REQ-007 SHALL have port an_n, output, 8: active-low digit-position select, bit k = position k, position 0 rightmost.
REQ-008 SHALL have port seg_n, output, 7: active-low segments, order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port pending, output, 1: captured value waiting for frame boundary.
REQ-010 SHALL have port frame_tick, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-011 On load=1, sign and d0..d6 SHALL be captured into a shadow register and pending SHALL be 1 from the next cycle.
REQ-012 A second load while pending SHALL overwrite the shadow (latest wins).
REQ-013 A prescaler SHALL count 0..SCAN_DIV-1; on terminal count, position counter SHALL advance 0..7, wrapping 7->0.
REQ-014 Frame boundary = terminal count with position 7; frame_tick SHALL be 1 exactly that cycle.
REQ-015 At frame boundary, if pending, shadow SHALL copy into display register and pending SHALL clear; display register SHALL change at no other time.
REQ-016 load coinciding with frame boundary: display takes the previous shadow content if pending was 1, else stays unchanged; new value SHALL be in shadow with pending=1.
REQ-017 Positions 0-6 SHALL show digits d0-d6; position 7 SHALL show minus (3F) when sign negative, else blank (7F).
REQ-018 Leading-zero blanking: positions above the highest nonzero digit SHALL be blank; position 0 SHALL never blank; all-zero value shows 40 at position 0.
REQ-019 Digit codes SHALL be 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10; A-F SHALL show E=06 and count as nonzero.
REQ-020 Negative zero SHALL still show minus at position 7.
REQ-021 an_n and seg_n SHALL be registered: one-clock latency from position/display register change.
REQ-022 Exactly one an_n bit SHALL be 0 at any time outside reset.

Reset
REQ-023 rst_n=0 SHALL immediately force an_n=FF, seg_n=7F, pending=0, frame_tick=0.
REQ-024 Reset SHALL clear prescaler, position (0), shadow and display (digits 0, sign non-negative); reset mid-frame discards pending data.
REQ-025 First clock after release SHALL produce an_n=FE, seg_n=40.

Structure
REQ-026 Segment code constants (digits, minus 3F, E 06, blank 7F) SHALL live in a shared display package reused by other display blocks.
REQ-027 Digit-to-segment decode SHALL be one combinational sub-module, bcd_to_seg; scanning, blanking and handshake stay in the top.

Verification (SCAN_DIV=4)
REQ-028 Reset: release rst_n -> an_n FE/seg 40 for 4 clocks, then positions 1-7 seg 7F, frame_tick at clock 32.
REQ-029 load positive=1, d=123 -> after next frame_tick: pos0 30, pos1 24, pos2 79, pos3-7 7F.
REQ-030 load positive=0, d=45 -> next frame: pos0 12, pos1 19, pos2-6 7F, pos7 3F.
REQ-031 load mid-frame then second load -> display unchanged until frame_tick; shows second value; pending 1 until cycle after boundary.
REQ-032 load d2=C, others 0 -> pos2 06, pos1 40, pos0 40, pos3-7 7F.
REQ-033 rst_n low during position 5 with pending=1 -> an_n FF, seg_n 7F same cycle; after release display 0, pending 0.
